// File: rtl/dis_pkg.sv
// dis_pkg: shared constants and state encoding for the display scan controller.
package dis_pkg;
    localparam int DW = 4;
    localparam logic [DW-1:0] BLANK_CODE = 4'hF;
    typedef enum logic {ST_BLANK, ST_SHOW} state_t;
endpackage

// File: rtl/dis_slot_timer.sv
// dis_slot_timer: per-digit slot counter and digit index with slot/frame end strobes.
module dis_slot_timer #(
    parameter int DIGITS = 8,
    parameter int SCAN_DIV = 50000,
    parameter int CW = 16,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic [IW-1:0] idx,
    output logic          slot_end,
    output logic          frame_end
);
    assign slot_end = en && cnt == CW'(SCAN_DIV - 1);
    assign frame_end = slot_end && idx == IW'(DIGITS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dis_scan_ctrl.sv
// dis_scan_ctrl: multiplexed 7-segment scan with dead time, leading-zero blanking
// and a shadow word that is committed only at frame boundaries.
module dis_scan_ctrl import dis_pkg::*; #(
    parameter int DIGITS = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD = 64,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DW*DIGITS-1:0] bcd_data,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic [DW-1:0]        BCD_num,
    output logic [DIGITS-1:0]    Dig_sel,
    output logic                 frame_done
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [DW*DIGITS-1:0] active, shadow;
    logic                 pending, accept, commit, hide, lit;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 slot_end, frame_end;
    logic [DW-1:0]        nib;
    state_t               st;

    dis_slot_timer #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .CW(CW), .IW(IW)) u_timer (
        .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .idx(idx),
        .slot_end(slot_end), .frame_end(frame_end)
    );

    assign load_ready = !pending;
    assign accept = load_valid && load_ready;
    // A dark display has no frame to tear, so a pending word lands immediately.
    assign commit = pending && (frame_end || !en);
    assign nib = active[DW*idx +: DW];
    assign hide = nib > 4'd9 || (LZ_SUPPRESS != 0 && idx != '0 && (active >> (DW*idx)) == '0);
    assign lit = st == ST_SHOW && !hide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            st         <= ST_BLANK;
            frame_done <= 1'b0;
            Dig_sel    <= '1;
            BCD_num    <= BLANK_CODE;
        end else begin
            if (accept) begin
                shadow  <= bcd_data;
                pending <= 1'b1;
            end else if (commit) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            st <= !en ? ST_BLANK : cnt == CW'(DEAD - 1) ? ST_SHOW : slot_end ? ST_BLANK : st;
            frame_done <= frame_end;
            Dig_sel <= lit ? ~(DIGITS'(1) << idx) : '1;
            BCD_num <= lit ? nib : BLANK_CODE;
        end
    end
endmodule

// File: tb/tb_dis_scan_ctrl.sv
// tb_dis_scan_ctrl: frame-position reference model checked every cycle against
// two instances (leading-zero blanking on and off), plus literal scenario checks.
module tb_dis_scan_ctrl;
    localparam int DIGITS = 4, SD = 8, DEAD = 2, FRAME = DIGITS * SD;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, load_valid = 1'b0;
    logic [15:0] bcd_data = '0;
    logic        rdy1, fd1, rdy0, fd0;
    logic [3:0]  bcd1, sel1, bcd0, sel0;

    dis_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SD), .DEAD(DEAD), .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .bcd_data(bcd_data), .load_valid(load_valid),
        .load_ready(rdy1), .BCD_num(bcd1), .Dig_sel(sel1), .frame_done(fd1));
    dis_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SD), .DEAD(DEAD), .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .bcd_data(bcd_data), .load_valid(load_valid),
        .load_ready(rdy0), .BCD_num(bcd0), .Dig_sel(sel0), .frame_done(fd0));

    always #5 clk = ~clk;

    // Reference: one position counter across the whole frame, pos = digit*SD + offset.
    int          pos, md, moff;
    logic [15:0] m_act, m_shd;
    logic        m_pend, mlz, mshow;
    logic [3:0]  mnib, e_sel1, e_bcd1, e_sel0, e_bcd0;
    logic        e_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0; m_act = '0; m_shd = '0; m_pend = 1'b0; e_fd = 1'b0;
            e_sel1 = 4'hF; e_bcd1 = 4'hF; e_sel0 = 4'hF; e_bcd0 = 4'hF;
        end else begin
            md = pos / SD;
            moff = pos % SD;
            mnib = m_act[4*md +: 4];
            mlz = md > 0 && (m_act >> (4 * md)) == 16'h0;
            mshow = moff >= DEAD && mnib <= 4'd9;
            e_sel1 = (mshow && !mlz) ? ~(4'b0001 << md) : 4'hF;
            e_bcd1 = (mshow && !mlz) ? mnib : 4'hF;
            e_sel0 = mshow ? ~(4'b0001 << md) : 4'hF;
            e_bcd0 = mshow ? mnib : 4'hF;
            e_fd = en && pos == FRAME - 1;
            if (load_valid && !m_pend) begin
                m_shd = bcd_data;
                m_pend = 1'b1;
            end else if (m_pend && (e_fd || !en)) begin
                m_act = m_shd;
                m_pend = 1'b0;
            end
            pos = en ? (pos + 1) % FRAME : 0;
        end
    end

    int          n_cmp = 0, n_fail = 0, lit_cnt = 0;
    logic [3:0]  mask1 = '0, mask0 = '0;
    logic [15:0] seen = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        mask1 = '0; mask0 = '0; seen = '0; lit_cnt = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("sel_lz1", sel1, e_sel1);
        chk("bcd_lz1", bcd1, e_bcd1);
        chk("fd_lz1", fd1, e_fd);
        chk("rdy_lz1", rdy1, !m_pend);
        chk("sel_lz0", sel0, e_sel0);
        chk("bcd_lz0", bcd0, e_bcd0);
        chk("fd_lz0", fd0, e_fd);
        chk("rdy_lz0", rdy0, !m_pend);
        for (int d = 0; d < DIGITS; d++) begin
            if (!sel1[d]) begin
                mask1[d] = 1'b1;
                seen[4*d +: 4] = bcd1;
                lit_cnt++;
            end
            if (!sel0[d]) mask0[d] = 1'b1;
        end
    endtask

    task automatic wait_fd();
        logic got = 1'b0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            tick();
            got = fd1;
        end
        chk("fd_timeout", got, 1'b1);
    endtask

    task automatic load_word(input logic [15:0] w);
        bcd_data = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("ready_fall", rdy1, 1'b0);
    endtask

    task automatic show_frame(input string name, input logic [15:0] w, input logic [3:0] m1,
                              input logic [3:0] m0);
        wait_fd();
        clr();
        repeat (FRAME) tick();
        chk({name, "_word"}, seen, w);
        chk({name, "_mask1"}, mask1, m1);
        chk({name, "_mask0"}, mask0, m0);
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++)
            w[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return w;
    endfunction

    initial begin
        int n;
        tick();
        chk("rst_sel", sel1, 4'hF);
        chk("rst_bcd", bcd1, 4'hF);
        chk("rst_rdy", rdy1, 1'b1);
        chk("rst_fd", fd1, 1'b0);
        rst_n = 1'b1;
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!fd1 && n < 100);
            chk("frame_len", n, FRAME);
        end
        clr();
        repeat (FRAME) tick();
        chk("zero_word", seen, 16'h0000);
        chk("zero_mask1", mask1, 4'b0001);
        repeat (5) tick();
        load_word(16'h1234);
        show_frame("w1234", 16'h1234, 4'b1111, 4'b1111);
        chk("lit_cycles", lit_cnt, 4 * (SD - DEAD));
        load_word(16'h0050);
        show_frame("w0050", 16'h0050, 4'b0011, 4'b1111);
        load_word(16'h9A12);
        show_frame("w9A12", 16'h9012, 4'b1011, 4'b1011);
        // Second word held while the first is pending.
        bcd_data = 16'h1111;
        load_valid = 1'b1;
        tick();
        bcd_data = 16'h2222;
        wait_fd();
        clr();
        tick();
        load_valid = 1'b0;
        chk("second_accept", rdy1, 1'b0);
        repeat (FRAME - 1) tick();
        chk("first_word", seen, 16'h1111);
        show_frame("second_word", 16'h2222, 4'b1111, 4'b1111);
        // Enable drop with a word pending.
        load_word(16'h0777);
        repeat (5) tick();
        en = 1'b0;
        tick();
        tick();
        chk("dark2", sel1, 4'hF);
        chk("en_commit", rdy1, 1'b1);
        en = 1'b1;
        clr();
        repeat (FRAME) tick();
        chk("en_word", seen, 16'h0777);
        chk("en_mask", mask1, 4'b0111);
        chk("en_fd", fd1, 1'b1);
        en = 1'b0;
        load_word(16'h0042);
        tick();
        chk("low_commit", rdy1, 1'b1);
        en = 1'b1;
        clr();
        repeat (FRAME) tick();
        chk("low_word", seen, 16'h0042);
        // Reset mid-frame discards the pending word.
        wait_fd();
        repeat (12) tick();
        load_word(16'h0300);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", sel1, 4'hF);
        chk("mid_rst_bcd", bcd1, 4'hF);
        chk("mid_rst_rdy", rdy1, 1'b1);
        tick();
        rst_n = 1'b1;
        show_frame("after_rst", 16'h0000, 4'b0001, 4'b1111);
        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 15) != 0;
            load_valid = $urandom_range(0, 3) == 0;
            bcd_data = rnd_word();
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
